// File: rtl/mips_boot_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM encoding and image framing.
package mips_boot_pkg;

    localparam logic [2:0] S_LEN_HI = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam int BYTES_PER_WORD = 4;
    localparam int HEADER_BYTES   = 2;

endpackage

// File: rtl/boot_word_packer.sv
// Packs a byte stream into big-endian 32-bit words; flags the byte that completes a word.
module boot_word_packer
    import mips_boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_complete,
    output logic [31:0] word
);

    logic [8*(BYTES_PER_WORD-1)-1:0] shreg;
    logic [1:0]                      byte_cnt;

    // The final byte is merged combinationally so the word is ready on the completing beat.
    assign word_complete = byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign word          = {shreg, byte_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (byte_valid) begin
            shreg    <= {shreg[8*(BYTES_PER_WORD-2)-1:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checked program image into instruction memory and
// holds the core in reset until the image is verified.
module imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int MAX_WORDS  = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    logic [2:0]       state;
    logic [15:0]      len;
    logic [IDX_W-1:0] word_index;
    logic [7:0]       chk_xor;
    logic             accept;
    logic             word_complete;
    logic [31:0]      packed_word;
    logic [15:0]      n_hdr;
    logic             last_word;

    assign rx_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CHECK);
    assign accept   = rx_valid && rx_ready;
    assign n_hdr    = {len[15:8], rx_data};
    assign last_word = (17'(word_index) + 17'd1) == {1'b0, len};

    boot_word_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .byte_valid    (accept && (state == S_DATA)),
        .byte_in       (rx_data),
        .word_complete (word_complete),
        .word          (packed_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_LEN_HI;
            len        <= '0;
            word_index <= '0;
            chk_xor    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_LEN_HI: begin
                        len[15:8] <= rx_data;
                        state     <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len <= n_hdr;
                        // Rejecting oversize here keeps word_index from ever wrapping.
                        if (32'(n_hdr) > 32'(MAX_WORDS)) begin
                            state      <= S_ERROR;
                            load_error <= 1'b1;
                        end else if (n_hdr == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        chk_xor <= chk_xor ^ rx_data;
                        if (word_complete) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= packed_word;
                            imem_addr  <= ADDR_WIDTH'({word_index, 2'b00});
                            word_index <= word_index + 1'b1;
                            if (last_word)
                                state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (rx_data == chk_xor) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state      <= S_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench: byte streams are parsed by a stream-level reference model and the
// observed memory writes and final status are compared against it.
module tb_imem_boot_loader;
    import mips_boot_pkg::*;

    localparam int MAX_WORDS  = 256;
    localparam int ADDR_WIDTH = 32;

    typedef logic [7:0] bq_t[$];

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [7:0]            rx_data = 8'h00;
    logic                  rx_valid = 1'b0;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_reset;
    logic                  load_done;
    logic                  load_error;

    int tests = 0;
    int fails = 0;

    imem_boot_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    // Write monitor: records every strobe and counts strobes lasting more than one cycle.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic        we_prev = 1'b0;
    int          pulse_err = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
        if (imem_we && we_prev)
            pulse_err <= pulse_err + 1;
        we_prev <= imem_we;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
        repeat (g) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        tests++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL load_ready: rx_ready=%b expected 1 while loading", rx_ready);
        end
    endtask

    // Drives a stream and checks writes/status against a model that parses the image format.
    task automatic run_stream(input string name, input bq_t s, input int gap_max, input bit rst_first);
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        logic [31:0] w;
        logic [7:0]  x;
        int          n, need, base, pe;
        bit          ok;
        bit          oversize;

        n = int'({s[0], s[1]});
        oversize = (n > MAX_WORDS);
        x = 8'h00;
        if (oversize) begin
            need = HEADER_BYTES;
            ok   = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                w = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
                ea.push_back(32'(i * 4));
                ed.push_back(w);
                x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            end
            need = HEADER_BYTES + 4 * n + 1;
            ok   = (s[need-1] == x);
        end

        base = wr_addr.size();
        pe   = pulse_err;
        if (rst_first)
            do_reset();
        for (int i = 0; i < need; i++)
            send_byte(s[i], gap_max);
        @(negedge clk);
        rx_valid = 1'b0;
        if (oversize) begin
            tests++;
            if (load_error !== 1'b1) begin
                fails++;
                $display("FAIL %s error_after_len: load_error=%b expected 1", name, load_error);
            end
        end
        for (int i = need; i < s.size(); i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = s[i];
            tests++;
            if (rx_ready !== 1'b0) begin
                fails++;
                $display("FAIL %s refuse_extra: rx_ready=%b expected 0", name, rx_ready);
            end
        end
        repeat (2) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end

        tests++;
        if (wr_addr.size() - base != ea.size()) begin
            fails++;
            $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr.size() - base, ea.size());
        end else begin
            for (int i = 0; i < ea.size(); i++) begin
                tests++;
                if ({wr_addr[base+i], wr_data[base+i]} !== {ea[i], ed[i]}) begin
                    fails++;
                    $display("FAIL %s write[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                             name, i, wr_addr[base+i], wr_data[base+i], ea[i], ed[i]);
                end
            end
        end
        tests++;
        if ({load_done, load_error, cpu_reset, rx_ready} !== {ok, !ok, !ok, 1'b0}) begin
            fails++;
            $display("FAIL %s status: done/err/cpu_reset/ready=%b%b%b%b expected %b%b%b0",
                     name, load_done, load_error, cpu_reset, rx_ready, ok, !ok, !ok);
        end
        tests++;
        if (pulse_err != pe) begin
            fails++;
            $display("FAIL %s we_pulse: %0d multi-cycle strobes expected 0", name, pulse_err - pe);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_error, rx_ready} !==
            {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_values: we=%b addr=%h wdata=%h cpu_reset=%b done=%b err=%b ready=%b",
                     imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_error, rx_ready);
        end
    endtask

    task automatic test_nominal();
        bq_t s;
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        run_stream("nominal", s, 0, 1'b1);
    endtask

    task automatic test_bad_checksum();
        bq_t s;
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0F};
        run_stream("bad_chk", s, 0, 1'b1);
    endtask

    task automatic test_oversize();
        bq_t s;
        s = '{8'h01, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        run_stream("oversize", s, 0, 1'b1);
    endtask

    task automatic test_zero_len();
        bq_t s;
        s = '{8'h00, 8'h00, 8'h00};
        run_stream("zero_len", s, 0, 1'b1);
    endtask

    task automatic test_gaps();
        bq_t s;
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E,
              8'h5A, 8'hC3, 8'h00};
        run_stream("gaps", s, 3, 1'b1);
    endtask

    task automatic test_reset_mid_load();
        bq_t s;
        int  base;
        base = wr_addr.size();
        do_reset();
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09};
        foreach (s[i])
            send_byte(s[i], 0);
        @(negedge clk);
        rx_valid = 1'b0;
        tests++;
        if (wr_addr.size() - base != 1) begin
            fails++;
            $display("FAIL mid_load_partial: %0d writes expected 1", wr_addr.size() - base);
        end
        do_reset();
        tests++;
        if ({imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_error, rx_ready} !==
            {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL mid_load_reset: we=%b addr=%h wdata=%h cpu_reset=%b done=%b err=%b ready=%b",
                     imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_error, rx_ready);
        end
        s = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        run_stream("after_reset", s, 0, 1'b0);
    endtask

    task automatic test_random();
        bq_t         s;
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        for (int t = 0; t < 10; t++) begin
            s.delete();
            if (t == 0)      n = MAX_WORDS;
            else if (t == 1) n = int'($urandom_range(65535, MAX_WORDS + 1));
            else             n = int'($urandom_range(6, 1));
            s.push_back(n[15:8]);
            s.push_back(n[7:0]);
            x = 8'h00;
            if (n <= MAX_WORDS) begin
                for (int i = 0; i < n; i++) begin
                    w = $urandom;
                    s.push_back(w[31:24]);
                    s.push_back(w[23:16]);
                    s.push_back(w[15:8]);
                    s.push_back(w[7:0]);
                    x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
                end
                if ($urandom_range(2, 0) == 0)
                    x = x ^ 8'($urandom_range(255, 1));
                s.push_back(x);
            end
            s.push_back(8'($urandom));
            run_stream($sformatf("random%0d", t), s, (t < 2) ? 0 : int'($urandom_range(2, 0)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_oversize();
        test_zero_len();
        test_gaps();
        test_reset_mid_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream neighbour of the single-cycle MIPS core.
- Receives a program image as a byte stream over a valid/ready interface, packs bytes into 32-bit big-endian words and writes them sequentially into instruction memory from address 0.
- Holds the core in reset (cpu_reset) until a complete, checksum-verified image is loaded, then releases it so execution starts at PC=0.

Parameters:
MAX_WORDS, 256, maximum number of instruction words accepted; a larger header length is an error.
ADDR_WIDTH, 32, width of imem_addr (byte address).

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
rx_data  input  8  incoming image byte
rx_valid  input  1  rx_data is valid this cycle
rx_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  one-cycle write strobe to instruction memory
imem_addr  output  ADDR_WIDTH  byte address of the write (word_index*4)
imem_wdata  output  32  instruction word to write
cpu_reset  output  1  held high until load succeeds; drives the core's reset
load_done  output  1  image loaded and verified
load_error  output  1  length or checksum error (sticky until reset)

Behaviour:
- Image format, in order: LEN_HI, LEN_LO (16-bit word count N, big-endian); then 4*N data bytes, each word big-endian (first byte -> bits 31:24); then one CHK byte equal to the XOR of all 4*N data bytes (header bytes excluded).
- A byte is accepted when rx_valid && rx_ready.
- rx_ready is a combinational decode of state: 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CHECK; 0 in S_DONE and S_ERROR.
- State transitions:
  - S_LEN_HI -> S_LEN_LO on accept.
  - S_LEN_LO on accept:
    - N > MAX_WORDS -> S_ERROR.
    - N == 0 -> S_CHECK.
    - Otherwise -> S_DATA.
  - S_DATA: accepts bytes while a 2-bit byte counter runs 0..3 and the running XOR updates. On the 4th byte of a word, the registered outputs update at the next edge: imem_we=1 for exactly one cycle, imem_wdata = assembled word, imem_addr = word_index*4. word_index then increments. After word N-1 is written -> S_CHECK.
  - S_CHECK on accept:
    - CHK == running XOR -> S_DONE.
    - Otherwise -> S_ERROR.
  - S_DONE: load_done=1, cpu_reset=0, stays until reset.
  - S_ERROR: load_error=1, cpu_reset=1, stays until reset.
- Registered outputs change on the same edge as the state transition.
- No data throughput penalty: with rx_valid held high, one byte is accepted every cycle. Write strobes are at most one per 4 cycles.
- Gaps in rx_valid stall the FSM with no state change; partial words are retained.
- imem_we is 0 at all times except the single pulse per word. imem_addr and imem_wdata hold their last values between pulses.
- Reset values: state=S_LEN_HI, so rx_ready=1 in the first cycle after reset. Also imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0. word_index, byte counter, length and XOR are all 0.
- Reset mid-load: all progress is discarded and the next accepted byte is treated as LEN_HI. Already-written memory words are not cleared.
- word_index never wraps: the MAX_WORDS check precedes S_DATA. The counter is wide enough for MAX_WORDS.

Decomposition:
- Shared package mips_boot_pkg holds:
  - State encoding: S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR.
  - BYTES_PER_WORD=4.
  - Header length of 2 bytes.
- One natural sub-module, boot_word_packer: a 4-byte shift register plus byte counter that asserts word_complete with the assembled word. The FSM, XOR, word_index and output registers stay in imem_boot_loader.

Test Plan:
- Nominal load: send 00 02 20 08 00 05 20 09 00 0A 0E.
  - imem_we pulses at addr 0x0 with 0x20080005 and at addr 0x4 with 0x2009000A.
  - After CHK: load_done=1, cpu_reset=0, rx_ready=0.
- Bad checksum: same stream with CHK=0F.
  - Both writes occur, then load_error=1, load_done=0, cpu_reset stays 1, rx_ready=0.
- Oversize: send 01 01 (257 > MAX_WORDS=256).
  - load_error=1 on the edge after LEN_LO; no imem_we pulses.
  - Further bytes are not accepted.
- Zero length: send 00 00 00.
  - load_done=1, cpu_reset=0, no imem_we pulses.
- Backpressure and gaps: nominal stream with rx_valid low for 1–3 cycles between random bytes.
  - Identical writes and result.
  - In S_DONE, rx_valid=1 with a byte gives no acceptance and no state change.
- Reset mid-load: after 00 02 20 08 00 05 20 09, pulse reset for 1 cycle.
  - All outputs return to reset values.
  - Then send 00 01 AA BB CC DD 00: single write addr 0x0 data 0xAABBCCDD, load_done=1 (AA^BB^CC^DD=00).
